// File: rtl/tone_divider.sv
// tone_divider: turns accepted note indices into a glitch-free square-wave tone.
// Each level of tone_out lasts H(n) = BASE_HALF - (n << STEP_SHIFT) clocks.
// A single pending-note register defers note changes to half-period boundaries.
// Optional feature macro: UNDERFLOW_CLAMP_EN (borrowed notes play as note 0
// instead of muting).
module tone_divider #(
  parameter int CNT_W      = 16,
  parameter int BASE_HALF  = 4000,
  parameter int STEP_SHIFT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] note_diff,
  input  logic       note_borrow,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic       key_off,
  output logic       tone_out,
  output logic       busy,
  output logic [4:0] note_q
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             pend_valid;
  logic [4:0]       pend_note;
  logic             pend_mute;
  logic             stop_flag;

  logic             accept;
  logic [4:0]       in_note;
  logic             in_mute;

  // Half-period for a note index, evaluated at counter width.
  function automatic logic [CNT_W-1:0] half_of(input logic [4:0] n);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(n);
    return CNT_W'(BASE_HALF) - (ext << STEP_SHIFT);
  endfunction

  // A new note is only taken when nothing is pending and no stop is being requested.
  assign note_ready = !pend_valid && !key_off;
  assign accept     = note_valid && note_ready;

  // Resolve an incoming note into the index to play and whether it mutes the tone.
  always_comb begin
    in_note = note_diff;
    in_mute = 1'b0;
`ifdef UNDERFLOW_CLAMP_EN
    if (note_borrow) begin
      in_note = 5'd0;
    end
`else
    if (note_borrow) begin
      in_mute = 1'b1;
    end
`endif
  end

  // Main sequencer: IDLE/RUN states, half-period countdown and pending-note handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      tone_out   <= 1'b0;
      busy       <= 1'b0;
      note_q     <= 5'd0;
      pend_valid <= 1'b0;
      pend_note  <= 5'd0;
      pend_mute  <= 1'b0;
      stop_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !in_mute) begin
            state    <= RUN;
            busy     <= 1'b1;
            tone_out <= 1'b1;
            note_q   <= in_note;
            counter  <= half_of(in_note) - CNT_ONE;
          end
        end

        RUN: begin
          if (counter != '0) begin
            counter <= counter - CNT_ONE;
            if (key_off) begin
              stop_flag  <= 1'b1;
              pend_valid <= 1'b0;
            end else if (accept) begin
              pend_valid <= 1'b1;
              pend_note  <= in_note;
              pend_mute  <= in_mute;
            end
          end else if (stop_flag || key_off || (pend_valid && pend_mute)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tone_out   <= 1'b0;
            stop_flag  <= 1'b0;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            tone_out   <= ~tone_out;
            note_q     <= pend_note;
            counter    <= half_of(pend_note) - CNT_ONE;
            pend_valid <= 1'b0;
          end else begin
            tone_out <= ~tone_out;
            counter  <= half_of(note_q) - CNT_ONE;
            if (accept) begin
              pend_valid <= 1'b1;
              pend_note  <= in_note;
              pend_mute  <= in_mute;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_divider.sv
// tb_tone_divider: directed checks of tone_divider.
// Instance A uses BASE_HALF=40, STEP_SHIFT=1; instance B uses the defaults.
module tb_tone_divider;

  localparam int LIMIT = 5000;

  logic       clk;
  logic       rst_n;
  logic [4:0] note_diff;
  logic       note_borrow;
  logic       note_valid;
  logic       key_off;

  logic       ready_a, tone_a, busy_a;
  logic [4:0] note_q_a;
  logic       ready_b, tone_b, busy_b;
  logic [4:0] note_q_b;

  int vec_count;
  int miscompares;

  typedef struct {
    logic [4:0] diff;
    logic       borrow;
    logic       exp_busy;
    int         exp_half;
    logic [4:0] exp_note;
  } vec_t;

  vec_t vectors[6];

  tone_divider #(.CNT_W(16), .BASE_HALF(40), .STEP_SHIFT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .note_diff(note_diff), .note_borrow(note_borrow),
    .note_valid(note_valid), .note_ready(ready_a), .key_off(key_off),
    .tone_out(tone_a), .busy(busy_a), .note_q(note_q_a)
  );

  tone_divider dut_b (
    .clk(clk), .rst_n(rst_n), .note_diff(note_diff), .note_borrow(note_borrow),
    .note_valid(note_valid), .note_ready(ready_b), .key_off(key_off),
    .tone_out(tone_b), .busy(busy_b), .note_q(note_q_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one note for a single cycle (the accepting edge is consumed here).
  task automatic applyStimulus(input logic [4:0] diff, input logic borrow);
    note_diff   = diff;
    note_borrow = borrow;
    note_valid  = 1'b1;
    tick();
    note_valid  = 1'b0;
  endtask

  task automatic doReset();
    note_valid = 1'b0;
    key_off    = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Count consecutive samples where the chosen instance's tone equals 'level'.
  task automatic measureLevel(input int which, input logic level, output int n);
    n = 0;
    while (((which == 0) ? tone_a : tone_b) == level && n < LIMIT) begin
      n++;
      tick();
    end
    if (n >= LIMIT) begin
      miscompares++;
      vec_count++;
      $display("[TB] FAIL level_timeout: got %0d cycles, expected fewer than %0d", n, LIMIT);
    end
  endtask

  // Count high samples over a window to prove the tone stays silent.
  task automatic countHighs(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      if (tone_a) n++;
      tick();
    end
  endtask

  initial begin
    int cnt;
    int rem;
    vec_count   = 0;
    miscompares = 0;
    note_diff   = 5'd0;
    note_borrow = 1'b0;
    note_valid  = 1'b0;
    key_off     = 1'b0;
    rst_n       = 1'b0;

    // H(n) = 40 - 2n for instance A
    vectors[0] = '{diff: 5'd0,  borrow: 1'b0, exp_busy: 1'b1, exp_half: 40, exp_note: 5'd0};
    vectors[1] = '{diff: 5'd5,  borrow: 1'b0, exp_busy: 1'b1, exp_half: 30, exp_note: 5'd5};
    vectors[2] = '{diff: 5'd10, borrow: 1'b0, exp_busy: 1'b1, exp_half: 20, exp_note: 5'd10};
    vectors[3] = '{diff: 5'd19, borrow: 1'b0, exp_busy: 1'b1, exp_half: 2,  exp_note: 5'd19};
    vectors[4] = '{diff: 5'd7,  borrow: 1'b0, exp_busy: 1'b1, exp_half: 26, exp_note: 5'd7};
`ifdef UNDERFLOW_CLAMP_EN
    vectors[5] = '{diff: 5'd3,  borrow: 1'b1, exp_busy: 1'b1, exp_half: 40, exp_note: 5'd0};
`else
    vectors[5] = '{diff: 5'd3,  borrow: 1'b1, exp_busy: 1'b0, exp_half: 0,  exp_note: 5'd0};
`endif

    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("reset_tone", int'(tone_a), 0);
    checkOutput("reset_busy", int'(busy_a), 0);
    checkOutput("reset_note_q", int'(note_q_a), 0);
    checkOutput("reset_ready", int'(ready_a), 1);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vectors[i].diff, vectors[i].borrow);
      checkOutput($sformatf("vec%0d_busy", i), int'(busy_a), int'(vectors[i].exp_busy));
      checkOutput($sformatf("vec%0d_note_q", i), int'(note_q_a), int'(vectors[i].exp_note));
      if (vectors[i].exp_busy) begin
        measureLevel(0, 1'b1, cnt);
        checkOutput($sformatf("vec%0d_high", i), cnt, vectors[i].exp_half);
        measureLevel(0, 1'b0, cnt);
        checkOutput($sformatf("vec%0d_low", i), cnt, vectors[i].exp_half);
        measureLevel(0, 1'b1, cnt);
        checkOutput($sformatf("vec%0d_high2", i), cnt, vectors[i].exp_half);
        checkOutput($sformatf("vec%0d_busy_run", i), int'(busy_a), 1);
      end else begin
        countHighs(60, cnt);
        checkOutput($sformatf("vec%0d_silent", i), cnt, 0);
        checkOutput($sformatf("vec%0d_busy_idle", i), int'(busy_a), 0);
      end
    end

    $display("[TB] note change mid-level");
    doReset();
    applyStimulus(5'd5, 1'b0);
    cnt = 0;
    repeat (10) begin cnt++; tick(); end
    cnt++;
    applyStimulus(5'd10, 1'b0);
    checkOutput("chg_ready_low", int'(ready_a), 0);
    checkOutput("chg_note_q_old", int'(note_q_a), 5);
    measureLevel(0, 1'b1, rem);
    checkOutput("chg_first_high", cnt + rem, 30);
    checkOutput("chg_note_q_new", int'(note_q_a), 10);
    checkOutput("chg_ready_back", int'(ready_a), 1);
    measureLevel(0, 1'b0, cnt);
    checkOutput("chg_low", cnt, 20);
    measureLevel(0, 1'b1, cnt);
    checkOutput("chg_high2", cnt, 20);

    $display("[TB] key_off mid-level");
    doReset();
    applyStimulus(5'd5, 1'b0);
    cnt = 0;
    repeat (10) begin cnt++; tick(); end
    key_off = 1'b1;
    #1;
    checkOutput("koff_ready_low", int'(ready_a), 0);
    cnt++;
    tick();
    key_off = 1'b0;
    checkOutput("koff_busy_still", int'(busy_a), 1);
    measureLevel(0, 1'b1, rem);
    checkOutput("koff_high", cnt + rem, 30);
    checkOutput("koff_busy", int'(busy_a), 0);
    checkOutput("koff_note_q_held", int'(note_q_a), 5);
    countHighs(50, cnt);
    checkOutput("koff_silent", cnt, 0);
    checkOutput("koff_ready", int'(ready_a), 1);

    $display("[TB] borrowed note pending in RUN");
    doReset();
    applyStimulus(5'd5, 1'b0);
    repeat (5) tick();
    applyStimulus(5'd3, 1'b1);
    measureLevel(0, 1'b1, rem);
    checkOutput("pend_borrow_high", rem + 6, 30);
`ifdef UNDERFLOW_CLAMP_EN
    checkOutput("pend_borrow_busy", int'(busy_a), 1);
    checkOutput("pend_borrow_note_q", int'(note_q_a), 0);
    measureLevel(0, 1'b0, cnt);
    checkOutput("pend_borrow_low", cnt, 40);
`else
    checkOutput("pend_borrow_busy", int'(busy_a), 0);
    checkOutput("pend_borrow_note_q", int'(note_q_a), 5);
`endif

    $display("[TB] asynchronous reset mid-level");
    doReset();
    applyStimulus(5'd5, 1'b0);
    repeat (7) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_tone", int'(tone_a), 0);
    checkOutput("areset_busy", int'(busy_a), 0);
    checkOutput("areset_note_q", int'(note_q_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("areset_ready", int'(ready_a), 1);

    $display("[TB] note 31 with default parameters");
    doReset();
    applyStimulus(5'd31, 1'b0);
    checkOutput("def_note_q", int'(note_q_b), 31);
    measureLevel(1, 1'b1, cnt);
    checkOutput("def_high", cnt, 2016);
    measureLevel(1, 1'b0, cnt);
    checkOutput("def_low", cnt, 2016);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_divider.md
Name: tone_divider

Overview:
- Downstream consumer of the 5-bit full subtractor's outputs: diff[4:0] (note index minus transpose) and b_out (borrow/underflow).
- Converts each accepted note index into a square-wave tone by counting down a programmable half-period.
- Holds one pending note so that note changes only take effect on half-period boundaries, which keeps tone_out glitch-free.
- Feeds the synth's audio mixer.

Parameters:
- CNT_W, 16, width of the half-period counter.
- BASE_HALF, 4000, half-period in clock cycles for note 0.
- STEP_SHIFT, 6, half-period reduction per note step is (1 << STEP_SHIFT).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- note_diff  in  5  note index from the subtractor (diff).
- note_borrow  in  1  subtractor borrow out (b_out); 1 means the transposed note is negative.
- note_valid  in  1  note_diff/note_borrow are valid this cycle.
- note_ready  out  1  block can accept a note this cycle.
- key_off  in  1  request to stop the tone at the next boundary.
- tone_out  out  1  square-wave output.
- busy  out  1  high in RUN state.
- note_q  out  5  note currently sounding.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tone_out=0, busy=0, note_q=0, counter=0, pending and stop flags cleared, note_ready=1 after reset releases.
- Half-period: H(n) = BASE_HALF - (n << STEP_SHIFT), computed at CNT_W bits. Defaults give H(0)=4000 and H(31)=2016. A parameter set giving H(31) < 2 is a configuration error.
- Handshake: a note is accepted when note_valid && note_ready on a rising edge. note_ready = !pend_valid && !key_off.
- IDLE, note accepted with borrow=0 (or with borrow=1 when clamped, see Optional Feature):
  - next cycle: state=RUN, busy=1, tone_out=1, note_q=n, counter=H(n)-1.
- IDLE, note accepted with borrow=1 and no clamp: note discarded; stay in IDLE.
- RUN, counter != 0: counter decrements by 1 each cycle.
- RUN, counter == 0 (boundary):
  - tone_out toggles, giving exactly H(n) cycles per level.
  - If stop pending: tone_out=0, state=IDLE, busy=0, stop and pending flags cleared, note_q held.
  - Else if pend_valid: note_q=pending note, counter=H(pending)-1, pend_valid cleared. A pending note with borrow=1 and no clamp is treated as a stop instead.
  - Else: counter=H(note_q)-1.
- RUN, note accepted: stored in the pending register, pend_valid=1, note_ready drops the next cycle.
- key_off:
  - In RUN: sets the stop flag and cancels any pending note.
  - In IDLE: no effect.
- A note accepted during the same boundary cycle that empties pending is not possible, because note_ready is low while pend_valid=1.
- Reset mid-tone: immediately returns to the reset state, with no completion of the half-period.

Optional Feature:
- UNDERFLOW_CLAMP_EN defined: a note with borrow=1 is played as note 0 (H=BASE_HALF), and note_q=0.
- UNDERFLOW_CLAMP_EN undefined: a note with borrow=1 acts as a mute. It is discarded in IDLE and acts as a stop when it reaches the boundary in RUN.

Test Plan:
- BASE_HALF=40, STEP_SHIFT=1: from IDLE send note 5 (H=30) -> tone_out=1 for 30 cycles, then 0 for 30 cycles, repeating; busy=1; note_q=5.
- While playing note 5, send note 10 (H=20) mid-half-period -> current 30-cycle level completes; subsequent levels are 20 cycles; note_ready=0 from acceptance until the boundary.
- While playing, assert key_off for 1 cycle -> current level finishes; tone_out=0, busy=0, state IDLE at that boundary.
- IDLE, send note_diff=3 with borrow=1 -> without macro: no tone, busy stays 0; with UNDERFLOW_CLAMP_EN: 40-cycle levels, note_q=0.
- Assert rst_n=0 asynchronously mid-level -> tone_out, busy, and note_q go to 0 immediately without waiting for a clock edge; note_ready=1 after release.
- Note 31 with defaults -> 2016-cycle levels.
